// File: rtl/readout_pkt_depacketizer_pkg.sv
// Readout packet format shared by the NI/ALU packetizer and the depacketizer.
// Holds the word-type codes, field positions, default field widths, the
// depacketizer state type and small helpers to build or take apart words, so
// producer and consumer cannot drift apart.
package readout_pkt_depacketizer_pkg;

  localparam int WORD_W    = 32;
  localparam int DEF_ID_W  = 5;
  localparam int DEF_OSC_W = 5;

  localparam logic [1:0] WT_HEAD = 2'b00;
  localparam logic [1:0] WT_BODY = 2'b01;
  localparam logic [1:0] WT_TAIL = 2'b11;

  // Word-type field and top of the reserved (must-be-zero) region.
  localparam int WT_MSB  = 31;
  localparam int WT_LSB  = 30;
  localparam int RSV_MSB = 29;

  // HEAD fields
  localparam int ID_MSB       = 9;
  localparam int ID_LSB       = 5;
  localparam int OSC_MSB      = 4;
  localparam int OSC_LSB      = 0;
  localparam int HEAD_RSV_LSB = 10;

  // BODY fields
  localparam int BODY_W       = 16;
  localparam int BODY_MSB     = 15;
  localparam int BODY_LSB     = 0;
  localparam int BODY_RSV_LSB = 16;

  // TAIL fields
  localparam int PAR_W        = 8;
  localparam int PAR_MSB      = 7;
  localparam int PAR_LSB      = 0;
  localparam int TAIL_RSV_LSB = 8;

  // Result record = {BODY data, TAIL parity}
  localparam int REC_W = BODY_W + PAR_W;

  typedef enum logic [1:0] {
    EXP_HEAD = 2'd0,
    EXP_BODY = 2'd1,
    EXP_TAIL = 2'd2
  } depkt_state_t;

  function automatic logic [WORD_W-1:0] pkt_head(input logic [DEF_ID_W-1:0]  id,
                                                 input logic [DEF_OSC_W-1:0] osc);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[WT_MSB:WT_LSB]   = WT_HEAD;
    w[ID_MSB:ID_LSB]   = id;
    w[OSC_MSB:OSC_LSB] = osc;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] pkt_body(input logic [BODY_W-1:0] data);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[WT_MSB:WT_LSB]     = WT_BODY;
    w[BODY_MSB:BODY_LSB] = data;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] pkt_tail(input logic [PAR_W-1:0] par);
    logic [WORD_W-1:0] w;
    w                  = '0;
    w[WT_MSB:WT_LSB]   = WT_TAIL;
    w[PAR_MSB:PAR_LSB] = par;
    return w;
  endfunction

  function automatic logic [1:0] word_type(input logic [WORD_W-1:0] w);
    return w[WT_MSB:WT_LSB];
  endfunction

endpackage

// File: rtl/readout_sat_counter.sv
// Saturating up-counter used for the depacketizer statistics.
// Ports:
//   clk, rstn  clock, async active-low reset
//   inc        count one event this cycle
//   clr        synchronous clear; an inc in the same cycle still counts,
//              so the result is 1 rather than 0
//   cnt        current count, sticks at all-ones
module readout_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/readout_pkt_depacketizer.sv
// Readout packet depacketizer. Pops words from the readout-network FIFO,
// reassembles HEAD/BODY/TAIL packets, writes one result record per good
// packet into the result RAM at {ID, Osc}, and keeps packet/error statistics.
//
// state    | meaning
// ---------+----------------------------------------------------------
// EXP_HEAD | idle between packets, only a good HEAD is accepted
// EXP_BODY | HEAD latched, waiting for the BODY word
// EXP_TAIL | HEAD and BODY latched, TAIL completes the packet
//
// Ports:
//   clk, rstn      clock, async active-low reset
//   Enable_i       permits FIFO reads
//   FifoEmpty_i    FIFO empty flag
//   FifoRd_o       FIFO read strobe (combinational)
//   FifoRdData_i   FIFO data, valid the cycle after FifoRd_o
//   ResWr_o        result RAM write pulse
//   ResAddr_o      {ID, Osc}, held until the next write
//   ResData_o      {BODY data, TAIL parity}, held until the next write
//   SweepDone_o    pulses with the write of ID==LAST_ID, Osc==NUM_OSC-1
//   ErrClr_i       clears Err_o and ErrCnt_o
//   Err_o          sticky framing-error flag
//   PktCnt_o       good-packet count, saturating
//   ErrCnt_o       framing-error count, saturating
module readout_pkt_depacketizer
  import readout_pkt_depacketizer_pkg::*;
#(
  parameter int              ID_W    = DEF_ID_W,
  parameter int              OSC_W   = DEF_OSC_W,
  parameter int              NUM_OSC = 25,
  parameter logic [ID_W-1:0] LAST_ID = ID_W'(7),
  parameter int              CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Enable_i,
  input  logic                    FifoEmpty_i,
  output logic                    FifoRd_o,
  input  logic [WORD_W-1:0]       FifoRdData_i,
  output logic                    ResWr_o,
  output logic [ID_W+OSC_W-1:0]   ResAddr_o,
  output logic [REC_W-1:0]        ResData_o,
  output logic                    SweepDone_o,
  input  logic                    ErrClr_i,
  output logic                    Err_o,
  output logic [CNT_W-1:0]        PktCnt_o,
  output logic [CNT_W-1:0]        ErrCnt_o
);

  // One extra bit so NUM_OSC == 2**OSC_W still compares correctly.
  localparam logic [OSC_W:0]   OSC_LIM  = (OSC_W + 1)'(NUM_OSC);
  localparam logic [OSC_W-1:0] LAST_OSC = OSC_W'(NUM_OSC - 1);

  depkt_state_t state_q, state_d;

  logic                rd_vld;
  logic [1:0]          w_type;
  logic [ID_W-1:0]     w_id;
  logic [OSC_W-1:0]    w_osc;
  logic [BODY_W-1:0]   w_data;
  logic [PAR_W-1:0]    w_par;
  logic                head_ok;
  logic                body_ok;
  logic                tail_ok;

  logic                latch_hd;
  logic                latch_body;
  logic                fire_wr;
  logic                frame_err;

  logic [ID_W-1:0]     id_q;
  logic [OSC_W-1:0]    osc_q;
  logic [BODY_W-1:0]   body_q;

  // ---------------------------------------------------------------- read side
  assign FifoRd_o = Enable_i & ~FifoEmpty_i;

  // Data follows the strobe by one cycle; a read already issued is processed
  // even if Enable_i drops in the meantime.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= FifoRd_o;
    end
  end

  // ---------------------------------------------------------- word classifier
  assign w_type = word_type(FifoRdData_i);
  assign w_id   = FifoRdData_i[ID_MSB:ID_LSB];
  assign w_osc  = FifoRdData_i[OSC_MSB:OSC_LSB];
  assign w_data = FifoRdData_i[BODY_MSB:BODY_LSB];
  assign w_par  = FifoRdData_i[PAR_MSB:PAR_LSB];

  // Malformed words (reserved bits set, Osc out of range) fall through to the
  // illegal branch of the FSM together with type 2'b10.
  always_comb begin
    head_ok = (w_type == WT_HEAD)
            && (FifoRdData_i[RSV_MSB:HEAD_RSV_LSB] == '0)
            && ({1'b0, w_osc} < OSC_LIM);
    body_ok = (w_type == WT_BODY)
            && (FifoRdData_i[RSV_MSB:BODY_RSV_LSB] == '0);
    tail_ok = (w_type == WT_TAIL)
            && (FifoRdData_i[RSV_MSB:TAIL_RSV_LSB] == '0);
  end

  // ---------------------------------------------------------- FSM: state reg
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EXP_HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    if (rd_vld) begin
      case (state_q)
        EXP_HEAD: begin
          if (head_ok) state_d = EXP_BODY;
        end
        EXP_BODY: begin
          if (body_ok)      state_d = EXP_TAIL;
          else if (head_ok) state_d = EXP_BODY;
          else              state_d = EXP_HEAD;
        end
        EXP_TAIL: begin
          if (tail_ok)      state_d = EXP_HEAD;
          else if (head_ok) state_d = EXP_BODY;
          else              state_d = EXP_HEAD;
        end
        default: state_d = EXP_HEAD;
      endcase
    end
  end

  // ---------------------------------------------------------- FSM: outputs
  // Every branch raises at most one frame_err, so a word never counts twice.
  always_comb begin
    latch_hd   = 1'b0;
    latch_body = 1'b0;
    fire_wr    = 1'b0;
    frame_err  = 1'b0;
    if (rd_vld) begin
      case (state_q)
        EXP_HEAD: begin
          if (head_ok) latch_hd  = 1'b1;
          else         frame_err = 1'b1;
        end
        EXP_BODY: begin
          if (body_ok) begin
            latch_body = 1'b1;
          end else if (head_ok) begin
            latch_hd  = 1'b1;
            frame_err = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        EXP_TAIL: begin
          if (tail_ok) begin
            fire_wr = 1'b1;
          end else if (head_ok) begin
            latch_hd  = 1'b1;
            frame_err = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: frame_err = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------- packet fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q   <= '0;
      osc_q  <= '0;
      body_q <= '0;
    end else begin
      if (latch_hd) begin
        id_q  <= w_id;
        osc_q <= w_osc;
      end
      if (latch_body) begin
        body_q <= w_data;
      end
    end
  end

  // ---------------------------------------------------------- result write
  // Parity comes straight off the TAIL word, so the record is complete in the
  // same cycle the TAIL is seen and the write lands one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ResWr_o     <= 1'b0;
      SweepDone_o <= 1'b0;
      ResAddr_o   <= '0;
      ResData_o   <= '0;
    end else begin
      ResWr_o     <= fire_wr;
      SweepDone_o <= fire_wr && (id_q == LAST_ID) && (osc_q == LAST_OSC);
      if (fire_wr) begin
        ResAddr_o <= {id_q, osc_q};
        ResData_o <= {body_q, w_par};
      end
    end
  end

  // ---------------------------------------------------------- error status
  // A new error in the clear cycle wins so it is never silently lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      Err_o <= 1'b0;
    end else if (frame_err) begin
      Err_o <= 1'b1;
    end else if (ErrClr_i) begin
      Err_o <= 1'b0;
    end
  end

  readout_sat_counter #(
    .W (CNT_W)
  ) u_pkt_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (fire_wr),
    .clr  (1'b0),
    .cnt  (PktCnt_o)
  );

  readout_sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (frame_err),
    .clr  (ErrClr_i),
    .cnt  (ErrCnt_o)
  );

endmodule

// File: tb/tb_readout_pkt_depacketizer.sv
module tb_readout_pkt_depacketizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        Enable_i;
  logic        FifoEmpty_i;
  logic        FifoRd_o;
  logic [31:0] FifoRdData_i;
  logic        ResWr_o;
  logic [9:0]  ResAddr_o;
  logic [23:0] ResData_o;
  logic        SweepDone_o;
  logic        ErrClr_i;
  logic        Err_o;
  logic [15:0] PktCnt_o;
  logic [15:0] ErrCnt_o;

  always #5 clk = ~clk;

  readout_pkt_depacketizer dut (
    .clk          (clk),
    .rstn         (rstn),
    .Enable_i     (Enable_i),
    .FifoEmpty_i  (FifoEmpty_i),
    .FifoRd_o     (FifoRd_o),
    .FifoRdData_i (FifoRdData_i),
    .ResWr_o      (ResWr_o),
    .ResAddr_o    (ResAddr_o),
    .ResData_o    (ResData_o),
    .SweepDone_o  (SweepDone_o),
    .ErrClr_i     (ErrClr_i),
    .Err_o        (Err_o),
    .PktCnt_o     (PktCnt_o),
    .ErrCnt_o     (ErrCnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ FIFO model
  logic [31:0] fifo_q[$];
  bit          rd_taken = 1'b0;

  always @(posedge clk) rd_taken = FifoRd_o;

  always @(negedge clk) begin
    if (rd_taken && fifo_q.size() > 0) FifoRdData_i = fifo_q.pop_front();
    FifoEmpty_i = (fifo_q.size() == 0);
  end

  // ------------------------------------------------------------ write monitor
  typedef struct {
    logic [9:0]  addr;
    logic [23:0] data;
    logic        sd;
    int          at;
  } wr_t;

  wr_t got_q[$];
  int  sd_cnt   = 0;
  int  sd_stray = 0;

  always @(negedge clk) begin
    wr_t t;
    if (rstn === 1'b1) begin
      if (ResWr_o === 1'b1) begin
        t.addr = ResAddr_o;
        t.data = ResData_o;
        t.sd   = SweepDone_o;
        t.at   = cyc;
        got_q.push_back(t);
      end
      if (SweepDone_o === 1'b1) begin
        sd_cnt++;
        if (ResWr_o !== 1'b1) sd_stray++;
      end
    end
  end

  // ------------------------------------------------------------ reference model
  // Packet-level view: a packet is "open" after a good HEAD and "has body"
  // after its BODY; counters are plain integers clamped at 65535.
  typedef struct {
    logic [9:0]  addr;
    logic [23:0] data;
    logic        sd;
  } exp_t;

  exp_t exp_q[$];
  bit   m_open = 0;
  bit   m_has_body = 0;
  int   m_id, m_osc, m_data;
  int   exp_err = 0;
  int   exp_pkt = 0;

  task automatic model_word(input logic [31:0] w);
    longint unsigned u     = w;
    longint unsigned typ   = u / (64'd1 << 30);
    longint unsigned low30 = u % (64'd1 << 30);
    bit head_g = (typ == 0) && (low30 / 1024 == 0) && (u % 32 < 25);
    bit body_g = (typ == 1) && (low30 / 65536 == 0);
    bit tail_g = (typ == 3) && (low30 / 256 == 0);
    exp_t e;
    if (head_g) begin
      if (m_open && exp_err < 65535) exp_err++;
      m_open     = 1;
      m_has_body = 0;
      m_id       = int'((u / 32) % 32);
      m_osc      = int'(u % 32);
    end else if (body_g && m_open && !m_has_body) begin
      m_has_body = 1;
      m_data     = int'(u % 65536);
    end else if (tail_g && m_has_body) begin
      e.addr = 10'(m_id * 32 + m_osc);
      e.data = 24'(m_data * 256 + int'(u % 256));
      e.sd   = (m_id == 7) && (m_osc == 24);
      exp_q.push_back(e);
      if (exp_pkt < 65535) exp_pkt++;
      m_open     = 0;
      m_has_body = 0;
    end else begin
      if (exp_err < 65535) exp_err++;
      m_open     = 0;
      m_has_body = 0;
    end
  endtask

  function automatic logic [31:0] mk_head(input int id, input int osc);
    return 32'(id * 32 + osc);
  endfunction
  function automatic logic [31:0] mk_body(input int d);
    return 32'h4000_0000 + 32'(d % 65536);
  endfunction
  function automatic logic [31:0] mk_tail(input int p);
    return 32'hC000_0000 + 32'(p % 256);
  endfunction

  task automatic send(input logic [31:0] w);
    fifo_q.push_back(w);
    model_word(w);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || rd_taken) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d words left, want 0", fifo_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic err_clear();
    @(negedge clk);
    ErrClr_i = 1'b1;
    @(negedge clk);
    ErrClr_i = 1'b0;
    exp_err  = 0;
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    sd_cnt   = 0;
    sd_stray = 0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ResWr_o, ResAddr_o, ResData_o, SweepDone_o, Err_o, PktCnt_o, ErrCnt_o, FifoRd_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h data=%h pkt=%h err=%h", ResAddr_o, ResData_o, PktCnt_o, ErrCnt_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ResWr_o, Err_o, PktCnt_o, ErrCnt_o} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got wr=%b err=%b pkt=%h errcnt=%h", ResWr_o, Err_o, PktCnt_o, ErrCnt_o);
    end
  endtask

  task automatic test_single_packet();
    start_test();
    send(32'h0000_00E3);
    send(32'h4000_ABCD);
    send(32'hC000_00A5);
    @(negedge clk);
    Enable_i = 1'b1;
    drain(50);
    Enable_i = 1'b0;
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL single_wr_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].addr !== 10'h0E3 || got_q[0].data !== 24'hABCDA5 || got_q[0].sd !== 1'b0) begin
        errors++;
        $display("FAIL single_record got %h/%h/%b want 0e3/abcda5/0", got_q[0].addr, got_q[0].data, got_q[0].sd);
      end
    end
    checks++;
    if (PktCnt_o !== 16'd1 || Err_o !== 1'b0 || ErrCnt_o !== 16'd0 || sd_cnt != 0) begin
      errors++;
      $display("FAIL single_status got pkt=%0d err=%b errcnt=%0d sd=%0d want 1/0/0/0", PktCnt_o, Err_o, ErrCnt_o, sd_cnt);
    end
  endtask

  task automatic test_full_sweep();
    int bad  = 0;
    int gaps = 0;
    start_test();
    for (int id = 0; id < 8; id++) begin
      for (int osc = 0; osc < 25; osc++) begin
        send(mk_head(id, osc));
        send(mk_body(int'($urandom_range(0, 65535))));
        send(mk_tail(int'($urandom_range(0, 255))));
      end
    end
    @(negedge clk);
    Enable_i = 1'b1;
    drain(2000);
    Enable_i = 1'b0;
    checks++;
    if (got_q.size() != 200 || exp_q.size() != 200) begin
      errors++;
      $display("FAIL sweep_wr_count got %0d want 200", got_q.size());
    end else begin
      for (int i = 0; i < 200; i++) begin
        if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].sd !== exp_q[i].sd) bad++;
        if (i > 0 && got_q[i].at - got_q[i-1].at != 3) gaps++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL sweep_records got %0d wrong records want 0", bad);
      end
      checks++;
      if (gaps != 0) begin
        errors++;
        $display("FAIL sweep_throughput got %0d stalled packets want 0", gaps);
      end
      checks++;
      if (got_q[199].addr !== {5'd7, 5'd24} || got_q[199].sd !== 1'b1) begin
        errors++;
        $display("FAIL sweep_last got addr=%h sd=%b want 0f8/1", got_q[199].addr, got_q[199].sd);
      end
    end
    checks++;
    if (sd_cnt != 1 || sd_stray != 0) begin
      errors++;
      $display("FAIL sweep_done_pulses got %0d (stray %0d) want 1", sd_cnt, sd_stray);
    end
    checks++;
    if (PktCnt_o !== 16'(exp_pkt) || ErrCnt_o !== 16'd0) begin
      errors++;
      $display("FAIL sweep_counts got pkt=%0d err=%0d want %0d/0", PktCnt_o, ErrCnt_o, exp_pkt);
    end
  endtask

  task automatic test_truncated();
    start_test();
    err_clear();
    send(mk_head(1, 2));
    send(mk_head(1, 3));
    send(mk_body(16'h1234));
    send(mk_tail(8'h5E));
    @(negedge clk);
    Enable_i = 1'b1;
    drain(50);
    Enable_i = 1'b0;
    checks++;
    if (ErrCnt_o !== 16'd1 || Err_o !== 1'b1) begin
      errors++;
      $display("FAIL trunc_err got cnt=%0d flag=%b want 1/1", ErrCnt_o, Err_o);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== 10'h023 || got_q[0].data !== 24'h12345E) begin
      errors++;
      $display("FAIL trunc_write got %0d writes first=%h want 1 at 023 data 12345e", got_q.size(),
               (got_q.size() > 0) ? got_q[0].addr : 10'h3FF);
    end
  endtask

  task automatic test_illegal();
    start_test();
    err_clear();
    send(32'h8000_0000);
    send(mk_head(0, 25));
    send(mk_tail(8'h5A));
    @(negedge clk);
    Enable_i = 1'b1;
    drain(50);
    checks++;
    if (ErrCnt_o !== 16'd3 || got_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_words got cnt=%0d writes=%0d want 3/0", ErrCnt_o, got_q.size());
    end
    send(mk_head(3, 4));
    send(mk_body(16'hBEEF));
    send(mk_tail(8'h3C));
    drain(50);
    Enable_i = 1'b0;
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== 10'h064 || got_q[0].data !== 24'hBEEF3C) begin
      errors++;
      $display("FAIL illegal_recover got %0d writes want 1 at 064 data beef3c", got_q.size());
    end
    checks++;
    if (ErrCnt_o !== 16'(exp_err)) begin
      errors++;
      $display("FAIL illegal_errcnt got %0d want %0d", ErrCnt_o, exp_err);
    end
  endtask

  task automatic test_err_clr();
    start_test();
    fifo_q.push_back(mk_body(16'h0F0F));
    @(negedge clk);
    Enable_i = 1'b1;
    @(posedge clk);
    #1 Enable_i = 1'b0;
    @(negedge clk);
    ErrClr_i = 1'b1;
    @(negedge clk);
    ErrClr_i = 1'b0;
    exp_err  = 0;
    model_word(mk_body(16'h0F0F));
    checks++;
    if (Err_o !== 1'b1 || ErrCnt_o !== 16'd1 || exp_err != 1) begin
      errors++;
      $display("FAIL clr_vs_err got flag=%b cnt=%0d want 1/1", Err_o, ErrCnt_o);
    end
    err_clear();
    checks++;
    if (Err_o !== 1'b0 || ErrCnt_o !== 16'd0) begin
      errors++;
      $display("FAIL clr_only got flag=%b cnt=%0d want 0/0", Err_o, ErrCnt_o);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int exp_sd = 0;
    start_test();
    Enable_i = 1'b1;
    for (int p = 0; p < 250; p++) begin
      int id   = int'($urandom_range(0, 31));
      int osc  = int'($urandom_range(0, 24));
      int kind = int'($urandom_range(0, 11));
      int d    = int'($urandom_range(0, 65535));
      int pr   = int'($urandom_range(0, 255));
      case (kind)
        0: begin send(mk_head(id, int'($urandom_range(25, 31)))); send(mk_body(d)); send(mk_tail(pr)); end
        1: begin send(mk_head(id, osc)); send(mk_tail(pr)); end
        2: begin send(mk_head(id, osc)); send(mk_body(d)); end
        3: begin send(mk_body(d)); send(mk_tail(pr)); end
        4: begin send(mk_head(id, osc)); send($urandom()); send(mk_body(d)); send(mk_tail(pr)); end
        5: begin send(mk_head(id, osc)); send(mk_head(7, 24)); send(mk_body(d)); send(mk_tail(pr)); end
        6: begin send(mk_head(id, osc)); send(mk_body(d) | 32'h0001_0000); send(mk_tail(pr)); end
        default: begin send(mk_head(id, osc)); send(mk_body(d)); send(mk_tail(pr)); end
      endcase
      if ($urandom_range(0, 4) == 0) begin
        Enable_i = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 5)) @(negedge clk);
        Enable_i = 1'b1;
      end
    end
    drain(5000);
    Enable_i = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_wr_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data || got_q[i].sd !== exp_q[i].sd) bad++;
        if (exp_q[i].sd) exp_sd++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_records got %0d wrong records want 0", bad);
      end
      checks++;
      if (sd_cnt != exp_sd || sd_stray != 0) begin
        errors++;
        $display("FAIL rand_sweep_done got %0d want %0d", sd_cnt, exp_sd);
      end
    end
    checks++;
    if (ErrCnt_o !== 16'(exp_err) || PktCnt_o !== 16'(exp_pkt) || Err_o !== (exp_err > 0)) begin
      errors++;
      $display("FAIL rand_counters got err=%0d pkt=%0d flag=%b want %0d/%0d", ErrCnt_o, PktCnt_o, Err_o, exp_err, exp_pkt);
    end
  endtask

  task automatic test_saturation();
    start_test();
    err_clear();
    for (int i = 0; i < 65535; i++) send(32'h8000_0000);
    @(negedge clk);
    Enable_i = 1'b1;
    drain(70000);
    checks++;
    if (ErrCnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach got %h want ffff", ErrCnt_o);
    end
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    drain(50);
    Enable_i = 1'b0;
    checks++;
    if (ErrCnt_o !== 16'hFFFF || exp_err != 65535 || Err_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got %h flag=%b want ffff/1", ErrCnt_o, Err_o);
    end
    checks++;
    if (PktCnt_o !== 16'(exp_pkt) || got_q.size() != 0) begin
      errors++;
      $display("FAIL sat_no_pkts got pkt=%0d writes=%0d want %0d/0", PktCnt_o, got_q.size(), exp_pkt);
    end
  endtask

  task automatic test_reset_mid();
    start_test();
    send(mk_head(2, 5));
    send(mk_body(16'h7777));
    @(negedge clk);
    Enable_i = 1'b1;
    drain(50);
    Enable_i = 1'b0;
    fifo_q.push_back(mk_tail(8'h11));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({ResWr_o, ResAddr_o, ResData_o, SweepDone_o, Err_o, PktCnt_o, ErrCnt_o, FifoRd_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got addr=%h data=%h pkt=%h err=%h flag=%b", ResAddr_o, ResData_o, PktCnt_o, ErrCnt_o, Err_o);
    end
    m_open     = 0;
    m_has_body = 0;
    exp_err    = 0;
    exp_pkt    = 0;
    @(negedge clk);
    rstn = 1'b1;
    model_word(mk_tail(8'h11));
    send(mk_head(4, 6));
    send(mk_body(16'hC0DE));
    send(mk_tail(8'h42));
    @(negedge clk);
    Enable_i = 1'b1;
    drain(50);
    Enable_i = 1'b0;
    checks++;
    if (ErrCnt_o !== 16'd1 || Err_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_leftover got cnt=%0d flag=%b want 1/1", ErrCnt_o, Err_o);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== 10'h086 || got_q[0].data !== 24'hC0DE42 || PktCnt_o !== 16'd1) begin
      errors++;
      $display("FAIL midreset_packet got %0d writes pkt=%0d want 1 at 086 data c0de42 pkt 1", got_q.size(), PktCnt_o);
    end
  endtask

  initial begin
    rstn         = 1'b0;
    Enable_i     = 1'b0;
    ErrClr_i     = 1'b0;
    FifoEmpty_i  = 1'b1;
    FifoRdData_i = '0;
    test_reset();
    test_single_packet();
    test_full_sweep();
    test_truncated();
    test_illegal();
    test_err_clr();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

endmodule
